// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: packs opcode, register fields and a 32-bit immediate
// into an RV32 instruction word (formats I/S/B/U/J), plus an LI pseudo-format
// that expands into LUI (+ ADDI). Valid/ready request side, one-entry
// registered output stage, two-state FSM for the second LI word.
// Optional feature macro: IMM_RANGE_CHECK_EN (immediate range checking and
// out_err reporting; when undefined fields are truncated and out_err is 0).
module imm_instr_encoder #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013,
  parameter logic [31:0] ERR_INSTR   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_S  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_U  = 3'd3;
  localparam logic [2:0] FMT_J  = 3'd4;
  localparam logic [2:0] FMT_LI = 3'd5;

  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_EMIT_LO = 1'b1
  } state_t;

  state_t      r_state;
  logic [4:0]  r_lo_rd;
  logic [11:0] r_lo_imm;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic        r_out_last;
  logic        r_out_err;

  logic        w_out_free;
  logic        w_accept;
  logic        w_drain;
  logic        w_fits12;
  logic [19:0] w_li_hi;
  logic [31:0] w_enc_instr;
  logic        w_enc_last;
  logic        w_enc_two;
  logic [31:0] w_word;
  logic        w_word_last;
  logic        w_word_err;
  logic        w_word_two;

  // ADDI rd,rs1,imm12 word builder
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm12);
    enc_addi = {imm12, rs1, 3'b000, rd, OP_OPIMM};
  endfunction

  assign w_out_free = !r_out_valid || out_ready;
  assign req_ready  = (r_state == ST_IDLE) && w_out_free;
  assign w_accept   = req_valid && req_ready;
  assign w_drain    = r_out_valid && out_ready;

  // The value fits a 12-bit signed field when bits 31..11 are a pure sign run.
  assign w_fits12 = (req_imm[31:11] == {21{req_imm[31]}});
  // Upper part of (imm + 0x800): a carry into bit 12 happens exactly when imm[11] is set.
  assign w_li_hi  = req_imm[31:12] + {19'd0, req_imm[11]};

  // Raw field packing for the requested format (no range checking here).
  always_comb begin
    w_enc_instr = RESET_INSTR;
    w_enc_last  = 1'b1;
    w_enc_two   = 1'b0;
    case (req_fmt)
      FMT_I: w_enc_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
      FMT_S: w_enc_instr = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
      FMT_B: w_enc_instr = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:1], req_imm[11], req_opcode};
      FMT_U: w_enc_instr = {req_imm[31:12], req_rd, req_opcode};
      FMT_J: w_enc_instr = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, req_opcode};
      FMT_LI: begin
        if (w_fits12) begin
          w_enc_instr = enc_addi(req_rd, 5'd0, req_imm[11:0]);
        end else begin
          w_enc_instr = {w_li_hi, req_rd, OP_LUI};
          w_enc_last  = (req_imm[11:0] == 12'd0);
          w_enc_two   = (req_imm[11:0] != 12'd0);
        end
      end
      // fmt 6/7 pack like I; with range checking enabled they are flagged below
      default: w_enc_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic w_range_bad;

  // Detect immediates that do not fit the target field, and illegal formats.
  always_comb begin
    w_range_bad = 1'b0;
    case (req_fmt)
      FMT_I, FMT_S: w_range_bad = !w_fits12;
      FMT_B:        w_range_bad = (req_imm[31:12] != {20{req_imm[31]}}) || req_imm[0];
      FMT_U:        w_range_bad = (req_imm[11:0] != 12'd0);
      FMT_J:        w_range_bad = (req_imm[31:20] != {12{req_imm[31]}}) || req_imm[0];
      FMT_LI:       w_range_bad = 1'b0;
      default:      w_range_bad = 1'b1;
    endcase
  end

  // A failed check replaces the word with the error word and ends the request.
  always_comb begin
    if (w_range_bad) begin
      w_word      = ERR_INSTR;
      w_word_last = 1'b1;
      w_word_err  = 1'b1;
      w_word_two  = 1'b0;
    end else begin
      w_word      = w_enc_instr;
      w_word_last = w_enc_last;
      w_word_err  = 1'b0;
      w_word_two  = w_enc_two;
    end
  end
`else
  // Without range checking the packed word is used as-is and never flagged.
  always_comb begin
    w_word      = w_enc_instr;
    w_word_last = w_enc_last;
    w_word_err  = 1'b0;
    w_word_two  = w_enc_two;
  end
`endif

  // Output register and LI expansion FSM: load on accept, then the pending
  // ADDI once the LUI leaves, otherwise fall back to the NOP word on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lo_rd     <= 5'd0;
      r_lo_imm    <= 12'd0;
      r_out_valid <= 1'b0;
      r_out_instr <= RESET_INSTR;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_word;
        r_out_last  <= w_word_last;
        r_out_err   <= w_word_err;
        r_lo_rd     <= req_rd;
        r_lo_imm    <= req_imm[11:0];
        r_state     <= w_word_two ? ST_EMIT_LO : ST_IDLE;
      end else if ((r_state == ST_EMIT_LO) && w_out_free) begin
        r_out_valid <= 1'b1;
        r_out_instr <= enc_addi(r_lo_rd, r_lo_rd, r_lo_imm);
        r_out_last  <= 1'b1;
        r_out_err   <= 1'b0;
        r_state     <= ST_IDLE;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
        r_out_instr <= RESET_INSTR;
        r_out_last  <= 1'b0;
        r_out_err   <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_last  = r_out_last;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed cases followed by
// randomized traffic compared against a word-queue reference model.
// Honours IMM_RANGE_CHECK_EN the same way the design does.
module tb_imm_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  int n_vec;
  int n_bad;

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } word_t;

  word_t q[$];

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  imm_instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fmt    (req_fmt),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input logic [31:0] instr, input logic last, input logic err);
    word_t w;
    w.instr = instr;
    w.last  = last;
    w.err   = err;
    return w;
  endfunction

  // Reference model: compute the word(s) a request produces with plain arithmetic.
  function automatic void model_req(input logic [2:0] fmt, input logic [6:0] op,
                                    input logic [2:0] f3, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] imm);
    int signed   sv;
    logic [31:0] w;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          bad;
    sv  = $signed(imm);
    bad = 1'b0;
    w   = 32'd0;
    case (fmt)
      3'd1: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
        bad = (sv < -2048) || (sv > 2047);
      end
      3'd2: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
            (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
            (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
        bad = (sv < -4096) || (sv > 4095) || (imm % 32'd2 != 32'd0);
      end
      3'd3: begin
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
        bad = (imm % 32'd4096 != 32'd0);
      end
      3'd4: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
            (32'(rd) << 7) | 32'(op);
        bad = (sv < -1048576) || (sv > 1048575) || (imm % 32'd2 != 32'd0);
      end
      3'd5: begin
        if (sv >= -2048 && sv <= 2047) begin
          q.push_back(mk((imm << 20) | (32'(rd) << 7) | 32'h13, 1'b1, 1'b0));
        end else begin
          hi = (imm + 32'h800) / 32'd4096;
          lo = imm % 32'd4096;
          q.push_back(mk((hi << 12) | (32'(rd) << 7) | 32'h37, lo == 32'd0, 1'b0));
          if (lo != 32'd0)
            q.push_back(mk((lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13, 1'b1, 1'b0));
        end
        return;
      end
      default: begin
        w = (imm << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        bad = (fmt != 3'd0) || (sv < -2048) || (sv > 2047);
      end
    endcase
    if (CHK && bad) q.push_back(mk(32'h00000000, 1'b1, 1'b1));
    else            q.push_back(mk(w, 1'b1, 1'b0));
  endfunction

  // One clock: compare DUT with the model before the edge, then advance the model.
  task automatic step();
    logic  exp_ready;
    word_t hd;
    #1;
    exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
    hd = (q.size() != 0) ? q[0] : mk(32'h00000013, 1'b0, 1'b0);
    chk("m_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("m_instr", out_instr, hd.instr);
    chk("m_last",  32'(out_last), 32'(hd.last));
    chk("m_err",   32'(out_err),  32'(hd.err));
    chk("m_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (req_valid && exp_ready)
      model_req(req_fmt, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm);
    @(negedge clk);
  endtask

  task automatic put(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm);
    req_valid  = 1'b1;
    req_fmt    = fmt;
    req_opcode = op;
    req_funct3 = f3;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_imm    = imm;
  endtask

  logic [31:0] edge_imm [12];

  initial begin
    edge_imm = '{32'h000007FF, 32'hFFFFF800, 32'h00000800, 32'hFFFFF7FF,
                 32'h00000FFF, 32'h00001000, 32'h7FFFF800, 32'h80000000,
                 32'hFFFFFFFF, 32'h00000FFE, 32'h12345000, 32'h000FFFFE};
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    put(3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h00000013);
    chk("rst_last",  32'(out_last), 32'd0);
    chk("rst_err",   32'(out_err), 32'd0);
    rst_n = 1'b1;
    step();

    // I: addi x5,x0,-1
    put(3'd0, 7'b0010011, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    step();
    req_valid = 1'b0;
    chk("i_instr", out_instr, 32'hFFF00293);
    chk("i_last", 32'(out_last), 32'd1);
    step();

    // B: beq x1,x2,+8 then the odd offset +3
    put(3'd2, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    step();
    req_valid = 1'b0;
    chk("b_instr", out_instr, 32'h00208463);
    step();
    put(3'd2, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    step();
    req_valid = 1'b0;
    chk("b_odd_instr", out_instr, CHK ? 32'h00000000 : 32'h00208163);
    chk("b_odd_err", 32'(out_err), 32'(CHK));
    step();

    // LI two-word expansion
    put(3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
    step();
    req_valid = 1'b0;
    chk("li_lui", out_instr, 32'h12346537);
    chk("li_lui_last", 32'(out_last), 32'd0);
    #1 chk("li_ready0", 32'(req_ready), 32'd0);
    step();
    chk("li_addi", out_instr, 32'hFFF50513);
    chk("li_addi_last", 32'(out_last), 32'd1);
    step();

    // LI single-word forms
    put(3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h00010000);
    step();
    put(3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'd5);
    chk("li_lui_only", out_instr, 32'h00010537);
    chk("li_lui_only_last", 32'(out_last), 32'd1);
    step();
    req_valid = 1'b0;
    chk("li_small", out_instr, 32'h00500513);
    step();

    // Backpressure across an LI expansion with a request waiting
    out_ready = 1'b0;
    put(3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
    step();
    put(3'd0, 7'b0010011, 3'd0, 5'd7, 5'd3, 5'd0, 32'h00000123);
    for (int i = 0; i < 4; i++) begin
      chk("bp_stable", out_instr, 32'h12346537);
      #1 chk("bp_ready0", 32'(req_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_addi", out_instr, 32'hFFF50513);
    step();
    req_valid = 1'b0;
    chk("bp_next", out_instr, 32'h12318393);
    step();
    step();

    // Reset while the ADDI is still pending
    out_ready = 1'b0;
    put(3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_instr", out_instr, 32'h00000013);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    put(3'd0, 7'b0010011, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    step();
    req_valid = 1'b0;
    chk("post_rst_i", out_instr, 32'hFFF00293);
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2:       imm = edge_imm[$urandom_range(0, 11)];
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      put(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), imm);
      req_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
